// File: rtl/ram_bus_master_if.sv
// Client request/response port and RAM control/address signals for ram_bus_master.
// The bidirectional RAM data net is not part of this bundle; it is a plain inout
// port on the master so that every bus driver resolves onto one net in the parent.
interface ram_bus_master_if #(
    parameter int addressWidth = 8,
    parameter int dataWidth    = 8,
    parameter int lengthWidth  = 4
);
    // Client request side
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [addressWidth-1:0] reqAddress;
    logic [lengthWidth-1:0]  reqLength;
    logic [dataWidth-1:0]    reqData;

    // Client response side
    logic                    rspValid;
    logic [dataWidth-1:0]    rspData;
    logic                    rspLast;

    // RAM control and address
    logic [addressWidth-1:0] ramAddress;
    logic                    ramSelect;
    logic                    ramWrite;
    logic                    ramOut;

    // The bus master: consumes requests, produces responses and RAM controls
    modport master (
        input  reqValid, reqWrite, reqAddress, reqLength, reqData,
        output reqReady,
        output rspValid, rspData, rspLast,
        output ramAddress, ramSelect, ramWrite, ramOut
    );

    // The other side: client issuing requests and RAM observing controls
    modport slave (
        output reqValid, reqWrite, reqAddress, reqLength, reqData,
        input  reqReady,
        input  rspValid, rspData, rspLast,
        input  ramAddress, ramSelect, ramWrite, ramOut
    );
endinterface

// File: rtl/ram_bus_master.sv
// RAM bus master: turns single-word write requests and pipelined burst-read
// requests into RAM bus cycles on a shared bidirectional data bus. The master
// only drives ramData during a WRITE cycle; every burst ends with one TURN cycle
// so the RAM has released the bus before the master may drive it again.
module ram_bus_master #(
    parameter int addressWidth = 8,
    parameter int dataWidth    = 8,
    parameter int lengthWidth  = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    ram_bus_master_if.master     bus,
    inout  wire  [dataWidth-1:0] ramData
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_LAST,
        TURN
    } stateType;

    stateType r_state;
    stateType w_nextState;

    // Captured request and burst progress
    logic [addressWidth-1:0] r_ramAddress;
    logic [lengthWidth-1:0]  r_count;
    logic [dataWidth-1:0]    r_writeData;
    logic                    r_firstRead;

    // Registered RAM controls and data-bus drive enable
    logic                    r_ramSelect;
    logic                    r_ramWrite;
    logic                    r_ramOut;
    logic                    r_drive;

    // Registered response outputs
    logic                    r_rspValid;
    logic [dataWidth-1:0]    r_rspData;
    logic                    r_rspLast;

    // Decoded control values for the cycle after the next clock edge
    logic                    w_accept;
    logic                    w_sample;
    logic                    w_selectNext;
    logic                    w_writeNext;
    logic                    w_outNext;

    // A request is taken only while idle; TURN deliberately keeps reqReady low.
    assign w_accept     = bus.reqValid && (r_state == IDLE);
    assign bus.reqReady = (r_state == IDLE);

    // The first READ cycle only presents the start address, so the bus holds a
    // stale value then; every later READ cycle and READ_LAST returns one beat.
    assign w_sample = ((r_state == READ) && !r_firstRead) || (r_state == READ_LAST);

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: a write is a single cycle, a read walks its addresses
    // and then spends one cycle in READ_LAST collecting the final beat
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = bus.reqWrite ? WRITE : READ;
                end
            end
            WRITE:     w_nextState = IDLE;
            READ: begin
                if (r_count == '0) begin
                    w_nextState = READ_LAST;
                end
            end
            READ_LAST: w_nextState = TURN;
            TURN:      w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered controls line up with it
    always_comb begin
        w_selectNext = 1'b0;
        w_writeNext  = 1'b0;
        w_outNext    = 1'b0;
        case (w_nextState)
            WRITE: begin
                w_selectNext = 1'b1;
                w_writeNext  = 1'b1;
            end
            READ, READ_LAST: begin
                w_selectNext = 1'b1;
                w_outNext    = 1'b1;
            end
            default: begin
                w_selectNext = 1'b0;
                w_writeNext  = 1'b0;
                w_outNext    = 1'b0;
            end
        endcase
    end

    // RAM control registers; the data-bus drive enable follows the write strobe
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_ramSelect <= 1'b0;
            r_ramWrite  <= 1'b0;
            r_ramOut    <= 1'b0;
            r_drive     <= 1'b0;
        end else begin
            r_ramSelect <= w_selectNext;
            r_ramWrite  <= w_writeNext;
            r_ramOut    <= w_outNext;
            r_drive     <= w_writeNext;
        end
    end

    // Request capture at accept, then address/beat stepping during READ
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_ramAddress <= '0;
            r_count      <= '0;
            r_writeData  <= '0;
            r_firstRead  <= 1'b0;
        end else if (w_accept) begin
            r_ramAddress <= bus.reqAddress;
            r_count      <= bus.reqLength;
            r_writeData  <= bus.reqData;
            r_firstRead  <= 1'b1;
        end else if (r_state == READ) begin
            r_firstRead <= 1'b0;
            if (r_count != '0) begin
                r_ramAddress <= r_ramAddress + addressWidth'(1);
                r_count      <= r_count - lengthWidth'(1);
            end
        end
    end

    // Response registers: one rspValid pulse per sampled beat, rspLast on the final one
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspLast  <= 1'b0;
        end else begin
            r_rspValid <= w_sample;
            r_rspLast  <= w_sample && (r_state == READ_LAST);
            if (w_sample) begin
                r_rspData <= ramData;
            end
        end
    end

    assign ramData = r_drive ? r_writeData : {dataWidth{1'bz}};

    assign bus.ramAddress = r_ramAddress;
    assign bus.ramSelect  = r_ramSelect;
    assign bus.ramWrite   = r_ramWrite;
    assign bus.ramOut     = r_ramOut;
    assign bus.rspValid   = r_rspValid;
    assign bus.rspData    = r_rspData;
    assign bus.rspLast    = r_rspLast;

endmodule

// File: tb/tb_ram_bus_master.sv
// Testbench for ram_bus_master: a behavioural RAM on the shared bus, a bus keeper
// pulling the data net to 0 whenever the RAM is deselected (so a stray master drive
// shows up), a reference memory, table-driven writes/reads, hand-written corner
// sequences and a randomized phase.
module tb_ram_bus_master;

    logic       clock;
    logic       resetN;
    wire  [7:0] ramData;

    int vectorsApplied = 0;
    int miscompares    = 0;

    ram_bus_master_if #(.addressWidth(8), .dataWidth(8), .lengthWidth(4)) bus ();

    ram_bus_master #(.addressWidth(8), .dataWidth(8), .lengthWidth(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus),
        .ramData(ramData)
    );

    // Behavioural RAM: write on select&write, otherwise latch the addressed word
    // while selected for output, and drive it during select&out&~write
    logic [7:0] ramMem [256];
    logic [7:0] ramQ;
    logic       ramDrive;
    logic       keeperEn;

    always @(posedge clock) begin
        if (bus.ramSelect && bus.ramWrite) begin
            ramMem[bus.ramAddress] <= ramData;
        end else if (bus.ramSelect && bus.ramOut) begin
            ramQ <= ramMem[bus.ramAddress];
        end
    end

    assign ramDrive = bus.ramSelect && bus.ramOut && !bus.ramWrite;
    assign keeperEn = !bus.ramSelect;
    assign ramData  = ramDrive ? ramQ  : 8'bz;
    assign ramData  = keeperEn ? 8'h00 : 8'bz;

    // Reference memory, updated when a write request is accepted
    logic [7:0] refMem [256];

    typedef struct {
        bit         isWrite;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] data;
        logic [7:0] expFirst;
        logic [7:0] expLast;
    } vectorType;

    vectorType vectors [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present a request at a falling edge, hold it until accepted, then scramble the
    // request fields so any late sampling by the master is caught
    task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                                 input logic [7:0] data, output int waits);
        waits = 0;
        @(negedge clock);
        bus.reqWrite   = wr;
        bus.reqAddress = addr;
        bus.reqLength  = len;
        bus.reqData    = data;
        bus.reqValid   = 1'b1;
        while (!bus.reqReady && waits < 40) begin
            @(negedge clock);
            waits++;
        end
        if (!bus.reqReady) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            bus.reqValid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            bus.reqValid   = 1'b0;
            bus.reqWrite   = ~wr;
            bus.reqAddress = ~addr;
            bus.reqLength  = ~len;
            bus.reqData    = ~data;
            if (wr) refMem[addr] = data;
        end
    endtask

    task automatic writeOnce(input logic [7:0] addr, input logic [7:0] data, output int waits);
        applyStimulus(1'b1, addr, 4'd0, data, waits);
        @(negedge clock);
        checkOutput("writeControls", {bus.ramSelect, bus.ramWrite, bus.ramOut}, 3'b110);
        checkOutput("writeAddress", bus.ramAddress, addr);
        checkOutput("writeData", ramData, data);
        checkOutput("writeReqReady", bus.reqReady, 1'b0);
        @(negedge clock);
        checkOutput("writeDone", {bus.ramSelect, bus.ramWrite, bus.ramOut}, 3'b000);
        checkOutput("writeReadyAgain", bus.reqReady, 1'b1);
    endtask

    // Beat i of an N-beat burst is expected in cycle i+2 after accept, data from the
    // reference memory at start+i-1 (mod 256), rspLast on beat N, then the bus idle
    task automatic readBurst(input logic [7:0] addr, input logic [3:0] len,
                             output logic [7:0] firstData, output logic [7:0] lastData, output int waits);
        int         n;
        int         beat;
        logic [7:0] expAddr;
        n = int'(len) + 1;
        beat = 0;
        firstData = 8'h00;
        lastData  = 8'h00;
        applyStimulus(1'b0, addr, len, 8'h00, waits);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clock);
            checkOutput("rspValid", bus.rspValid, k >= 3);
            checkOutput("readReqReady", bus.reqReady, 1'b0);
            if (k <= n + 1) begin
                expAddr = (k <= n) ? addr + 8'(k - 1) : addr + 8'(n - 1);
                checkOutput("readControls", {bus.ramSelect, bus.ramOut, bus.ramWrite}, 3'b110);
                checkOutput("readAddress", bus.ramAddress, expAddr);
            end else begin
                checkOutput("turnControls", {bus.ramSelect, bus.ramOut, bus.ramWrite}, 3'b000);
                checkOutput("turnBusZ", ramData, 8'h00);
            end
            if (k >= 3 && bus.rspValid) begin
                checkOutput("rspData", bus.rspData, refMem[addr + 8'(beat)]);
                checkOutput("rspLast", bus.rspLast, beat == n - 1);
                if (beat == 0) firstData = bus.rspData;
                lastData = bus.rspData;
                beat++;
            end
        end
    endtask

    // Bus monitor: no contention while the RAM drives, nothing driven while the RAM
    // is deselected, and the output enable never overlaps a write strobe
    always @(negedge clock) begin
        if (bus.ramSelect && bus.ramOut && !bus.ramWrite) begin
            checkOutput("ramDriveClean", ramData, ramQ);
        end
        if (!bus.ramSelect) begin
            checkOutput("busIdleZ", ramData, 8'h00);
        end
        checkOutput("writeOutExclusive", bus.ramSelect & bus.ramWrite & bus.ramOut, 1'b0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         waits;
        logic [7:0] firstData;
        logic [7:0] lastData;

        bus.reqValid   = 1'b0;
        bus.reqWrite   = 1'b0;
        bus.reqAddress = 8'h00;
        bus.reqLength  = 4'd0;
        bus.reqData    = 8'h00;
        resetN = 1'b1;

        // Reset state
        #1 resetN = 1'b0;
        #2;
        checkOutput("resetControls", {bus.ramSelect, bus.ramWrite, bus.ramOut}, 3'b000);
        checkOutput("resetBusZ", ramData, 8'h00);
        checkOutput("resetReqReady", bus.reqReady, 1'b1);
        checkOutput("resetRspValid", bus.rspValid, 1'b0);
        checkOutput("resetAddress", bus.ramAddress, 8'h00);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;

        // Directed table: single write/read, 4-beat burst, address wrap
        vectors.push_back('{1'b1, 8'h05, 4'd0, 8'hA5, 8'h00, 8'h00});
        vectors.push_back('{1'b0, 8'h05, 4'd0, 8'h00, 8'hA5, 8'hA5});
        vectors.push_back('{1'b1, 8'h10, 4'd0, 8'h11, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'h11, 4'd0, 8'h22, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'h12, 4'd0, 8'h33, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'h13, 4'd0, 8'h44, 8'h00, 8'h00});
        vectors.push_back('{1'b0, 8'h10, 4'd3, 8'h00, 8'h11, 8'h44});
        vectors.push_back('{1'b1, 8'hFE, 4'd0, 8'hE1, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'hFF, 4'd0, 8'hE2, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'h00, 4'd0, 8'hE3, 8'h00, 8'h00});
        vectors.push_back('{1'b1, 8'h01, 4'd0, 8'hE4, 8'h00, 8'h00});
        vectors.push_back('{1'b0, 8'hFE, 4'd3, 8'h00, 8'hE1, 8'hE4});

        for (int i = 0; i < vectors.size(); i++) begin
            if (vectors[i].isWrite) begin
                writeOnce(vectors[i].addr, vectors[i].data, waits);
            end else begin
                readBurst(vectors[i].addr, vectors[i].len, firstData, lastData, waits);
                checkOutput("tableFirstBeat", firstData, vectors[i].expFirst);
                checkOutput("tableLastBeat", lastData, vectors[i].expLast);
            end
        end

        // Read immediately followed by a write: accepted in the first cycle after TURN
        readBurst(8'h05, 4'd0, firstData, lastData, waits);
        writeOnce(8'h06, 8'h6C, waits);
        checkOutput("writeAfterReadWaits", waits, 0);
        readBurst(8'h06, 4'd0, firstData, lastData, waits);
        checkOutput("writeAfterReadData", firstData, 8'h6C);

        // Reset in the middle of beat 3 of an 8-beat burst
        applyStimulus(1'b0, 8'h10, 4'd7, 8'h00, waits);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            checkOutput("preResetRspValid", bus.rspValid, k >= 3);
            if (k == 3) checkOutput("preResetBeat1", bus.rspData, 8'h11);
            if (k == 4) checkOutput("preResetBeat2", bus.rspData, 8'h22);
            if (k == 5) checkOutput("preResetBeat3", bus.rspData, 8'h33);
        end
        resetN = 1'b0;
        #1;
        checkOutput("midResetControls", {bus.ramSelect, bus.ramWrite, bus.ramOut}, 3'b000);
        checkOutput("midResetRsp", {bus.rspValid, bus.rspLast, bus.rspData}, 10'h000);
        checkOutput("midResetAddress", bus.ramAddress, 8'h00);
        checkOutput("midResetReqReady", bus.reqReady, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("inResetRspValid", bus.rspValid, 1'b0);
        end
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("postResetRspValid", bus.rspValid, 1'b0);
            checkOutput("postResetReqReady", bus.reqReady, 1'b1);
        end
        writeOnce(8'h20, 8'h5A, waits);
        readBurst(8'h20, 4'd0, firstData, lastData, waits);
        checkOutput("postResetReadBack", firstData, 8'h5A);

        // Randomized phase: fill a window, then mix random writes and bursts inside it
        for (int a = 8'hC0; a <= 8'hDF; a++) begin
            writeOnce(8'(a), 8'($urandom), waits);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                writeOnce(8'(8'hC0 + $urandom_range(0, 31)), 8'($urandom), waits);
            end else begin
                readBurst(8'(8'hC0 + $urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          firstData, lastData, waits);
            end
        end

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
